updown_mod16_counter: RTL and testbench
=======================================

// Module: updown_mod16_counter
// PURPOSE
//   Free-running synchronous up/down counter with a parameterised modulus.
//   - mode=0: counts up. mode=1: counts down. Wraps at both ends.
//   - Default build is modulo-16 (0..15) on a 5-bit output bus.
//   - General-purpose sequencing/timing source. No enable, load or
//     handshake: it advances on every clock edge while out of reset.
// PARAMETERS
//   WIDTH     5   width of q in bits
//   MAX_COUNT 15  terminal (highest) count value
//                 - Legal range: 1 .. 2**WIDTH-1.
//                 - Modulus = MAX_COUNT+1.
// PORTS
//   clk    in   1      single clock; all state changes on its rising edge
//   reset  in   1      asynchronous, active-high reset; forces q to 0
//   mode   in   1      direction: 0 = count up, 1 = count down
//   q      out  WIDTH  current count; driven directly from a register
// BEHAVIOUR
//   - One clock domain (clk). Reset is asynchronous and active-high.
//   - Reset:
//     - While reset=1, q=0 immediately, without waiting for a clock edge.
//     - On deassertion, the first rising clk edge with reset=0 performs
//       the first count step.
//     - Asserting reset mid-count clears q at once, regardless of mode.
//   - Count step, on each rising clk edge with reset=0:
//     - mode=0: q = (q==MAX_COUNT) ? 0 : q+1
//     - mode=1: q = (q==0) ? MAX_COUNT : q-1
//   - Latency and timing:
//     - q updates on the same edge at which mode is sampled.
//     - A mode change takes effect on the next rising edge.
//     - No glitches on q (registered output).
//   - Range and width:
//     - q never exceeds MAX_COUNT.
//     - With default parameters q[4] is always 0 and q cycles 0..15.
//     - Arithmetic is done in WIDTH bits; the wrap compare is explicit, so
//       the result does not depend on natural binary overflow.
//   - Out-of-range state (q > MAX_COUNT, only via illegal state):
//     - next edge loads 0 when mode=0, MAX_COUNT when mode=1.
//   - Simultaneous events:
//     - Reset has priority over any count step.
//     - A mode toggle exactly at a wrap boundary uses the newly sampled
//       mode.
//   - No other state: the counter register is the entire design.
// TESTING
//   All vectors use the default parameters and a 10 ns clk period.
//   1. Reset high, then low, mode=0 -> q=0 during reset;
//      q=4 after 4 rising edges.
//   2. Continue mode=0 -> after 15 edges q=15 (5'b01111);
//      the next edge gives q=0 (wrap up).
//   3. Starting from q=0, set mode=1 -> the next edge gives q=15
//      (wrap down); 5 more edges give q=10 (5'b01010).
//   4. mode=1 held for 16 edges from q=10 -> q returns to 10;
//      the sequence is strictly decreasing modulo 16.
//   5. Assert reset between clock edges while q=7 -> q=0 before the next
//      edge; q stays 0 until reset is released.
//   6. Toggle mode every 3 edges from 0 -> q follows 1,2,3,2,1,0,1,...;
//      q[4] is never 1.

Source files
------------

// File: rtl/updown_mod16_counter_if.sv
// updown_mod16_counter_if: direction input and count output of the up/down counter
interface updown_mod16_counter_if #(
  parameter int WIDTH = 5
);
  logic             mode;
  logic [WIDTH-1:0] q;
  modport master (output mode, input q);
  modport slave (input mode, output q);
endinterface

// File: rtl/updown_mod16_counter.sv
// updown_mod16_counter: free-running up/down counter, modulus MAX_COUNT+1, async active-high reset
module updown_mod16_counter #(
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 15
) (
  input logic                 clk,
  input logic                 reset,
  updown_mod16_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] q_q, q_d;
  // next count: explicit wrap compares; an out-of-range value recovers to the wrap target of the direction
  always_comb begin
    q_d = bus.mode ? ((q_q == '0 || q_q > MAX) ? MAX : q_q - ONE)
                   : ((q_q >= MAX) ? '0 : q_q + ONE);
  end
  // count register, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end
  assign bus.q = q_q;
endmodule

// File: tb/tb_updown_mod16_counter.sv
// tb_updown_mod16_counter: directed checks of the default modulo-16 up/down counter
module tb_updown_mod16_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  logic [4:0] exp;
  logic [4:0] seq6 [12] = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0};

  updown_mod16_counter_if #(.WIDTH(5)) bus ();
  updown_mod16_counter #(.WIDTH(5), .MAX_COUNT(15)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.mode = 1'b0;
    #3;
    check("reset_async_initial", bus.q, 5'd0);
    tick(2);
    check("reset_held", bus.q, 5'd0);
    reset = 1'b0;
    tick(4);
    check("up_after_4", bus.q, 5'd4);
    tick(11);
    check("up_reach_15", bus.q, 5'd15);
    tick(1);
    check("wrap_up", bus.q, 5'd0);
    bus.mode = 1'b1;
    tick(1);
    check("wrap_down", bus.q, 5'd15);
    tick(5);
    check("down_to_10", bus.q, 5'd10);
    exp = 5'd10;
    for (int i = 0; i < 16; i++) begin
      exp = (exp == 5'd0) ? 5'd15 : exp - 5'd1;
      tick(1);
      check($sformatf("down_seq_%0d", i), bus.q, exp);
    end
    check("down_full_cycle", bus.q, 5'd10);
    tick(3);
    check("down_to_7", bus.q, 5'd7);
    #2 reset = 1'b1;
    #1 check("reset_mid_cycle", bus.q, 5'd0);
    tick(3);
    check("reset_hold_edges", bus.q, 5'd0);
    bus.mode = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0 && i != 0) bus.mode = ~bus.mode;
      tick(1);
      check($sformatf("toggle_seq_%0d", i), bus.q, seq6[i]);
      check($sformatf("toggle_msb_%0d", i), {4'd0, bus.q[4]}, 5'd0);
    end
    bus.mode = 1'b1;
    tick(1);
    check("toggle_at_wrap", bus.q, 5'd15);
    bus.mode = 1'b0;
    tick(1);
    check("toggle_back_wrap", bus.q, 5'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
